// File: rtl/loader_pkg.sv
// loader_pkg -- shared types and constants for the UART instruction-memory loader.
//   ld_state_e     : loader FSM states
//   rx_state_e     : UART receiver states
//   BYTES_PER_WORD : data bytes per instruction word
//   LEN_BYTES      : bytes in the little-endian word-count header
package loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with an input synchronizer.
//   clk, rst   : system clock, synchronous active-high reset
//   rx_i       : asynchronous serial line, idle high
//   byte_valid : 1-cycle pulse when a byte arrives with a good stop bit
//   byte_data  : received byte, valid with byte_valid
//   frame_err  : 1-cycle pulse when the stop bit is sampled low
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d   = state_q;
        rx_meta_d = rx_i;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        ferr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                // Only a real high-to-low edge starts a frame, so a line held
                // low after a framing error does not retrigger.
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // Short glitches are high again by mid-bit: drop them.
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            rx_prev_q <= rx_prev_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ferr_q    <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = data_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader -- loads a program image from a UART into instruction memory
// and holds the core in reset until the load completes.
//   clk, rst   : system clock, synchronous active-high reset
//   rx_i       : asynchronous UART line, idle high
//   imem_we    : 1-cycle write strobe per word
//   imem_addr  : word address of the write
//   imem_wdata : instruction word
//   core_rst   : core reset, low only once the image is loaded
//   load_done  : image loaded, core released
//   load_err   : load aborted (oversize count, framing error, bad checksum)
// Image: 16-bit LE word count N, then N 32-bit LE words.
// Optional macro LOADER_CHECKSUM_EN: a trailing byte equal to the XOR of all
// data bytes is required before the core is released.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [31:0] MAX_WORDS    = 32'd1 << ADDR_W;
    localparam int          BCNT_W       = $clog2(BYTES_PER_WORD);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    ld_state_e         state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [23:0]       buf_q, buf_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;     // one extra bit: counts up to 2**ADDR_W
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic [15:0]       n_len;

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        bcnt_d   = bcnt_q;
        buf_d    = buf_q;
        wcnt_d   = wcnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        n_len    = {byte_data, len_lo_q};
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        if (frame_err && state_q != DONE && state_q != ERROR) begin
            state_d = ERROR;
        end else begin
            case (state_q)
                LEN_LO: begin
                    if (byte_valid) begin
                        len_lo_d = byte_data;
                        state_d  = LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (byte_valid) begin
                        len_d = n_len;
                        // The limit guarantees the write address never wraps.
                        if (32'(n_len) > MAX_WORDS) state_d = ERROR;
                        else if (n_len == 16'd0)     state_d = CHECK;
                        else                         state_d = DATA;
                    end
                end
                DATA: begin
                    if (byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
                        csum_d = csum_q ^ byte_data;
`endif
                        if (bcnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
                            we_d    = 1'b1;
                            wdata_d = {byte_data, buf_q};
                            addr_d  = wcnt_q[ADDR_W-1:0];
                            wcnt_d  = wcnt_q + 1'b1;
                            bcnt_d  = '0;
                            if (32'(wcnt_q) + 32'd1 == 32'(len_q)) state_d = CHECK;
                        end else begin
                            // Bytes arrive LSB first: shift in from the top.
                            buf_d  = {byte_data, buf_q[23:8]};
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
                CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (byte_valid) state_d = (byte_data == csum_q) ? DONE : ERROR;
`else
                    state_d = DONE;
`endif
                end
                default: ;  // DONE and ERROR ignore all traffic
            endcase
        end
        // Outputs decoded from the next state so they are registered and
        // core_rst drops the cycle after the final write strobe.
        core_rst_d = (state_d != DONE);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LEN_LO;
            len_lo_q   <= '0;
            len_q      <= '0;
            bcnt_q     <= '0;
            buf_q      <= '0;
            wcnt_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            bcnt_q     <= bcnt_d;
            buf_q      <= buf_d;
            wcnt_q     <= wcnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule
